// File: rtl/kronos_lsu_q.sv
// Load/store unit with a DEPTH-entry request queue and a single-issue bus FSM.
// Define KRONOS_LSU_MISALIGN_EN to split misaligned accesses into two word accesses.
module kronos_lsu_q #(
   parameter int unsigned DEPTH     = 2,
   parameter logic [31:0] BOOT_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        rstz,
   input  logic        req_vld,
   output logic        req_rdy,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        req_ld,
   input  logic        req_st,
   input  logic [1:0]  req_size,
   input  logic        req_uns,
   input  logic [4:0]  req_rd,
   input  logic        flush,
   output logic [31:0] data_addr,
   output logic [31:0] data_wr_data,
   output logic [3:0]  data_wr_mask,
   output logic        data_rd_req,
   output logic        data_wr_req,
   input  logic [31:0] data_rd_data,
   input  logic        data_gnt,
   output logic [31:0] load_data,
   output logic [4:0]  load_rd,
   output logic        load_write,
   output logic        store_done,
   output logic        misaligned,
   output logic        busy,
   output logic [31:0] last_addr
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        ld;
      logic        st;
      logic [1:0]  size;
      logic        uns;
      logic [4:0]  rd;
   } entry_t;

   function automatic logic is_mis(input logic [1:0] size, input logic [1:0] off);
      return (size == 2'd1 && off == 2'd3) || (size[1] && off != 2'd0);
   endfunction

   function automatic logic [31:0] ld_ext(input logic [1:0] size, input logic uns,
                                          input logic [1:0] off, input logic [31:0] lo,
                                          input logic [31:0] hi);
      logic [31:0] w;
      w = 32'({hi, lo} >> {off, 3'b000});
      case (size)
         2'd0:    return uns ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
         2'd1:    return uns ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
         default: return w;
      endcase
   endfunction

   entry_t          q_mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   state_t          state_q, state_d;
   entry_t          cur_q, cur_d;
   logic            split_q, split_d;
   logic [31:0]     lo_q, lo_d, spill_data_q, spill_data_d;
   logic [3:0]      spill_mask_q, spill_mask_d;
   logic [31:0]     data_addr_q, data_addr_d, data_wr_data_q, data_wr_data_d;
   logic [3:0]      data_wr_mask_q, data_wr_mask_d;
   logic            data_rd_req_q, data_rd_req_d, data_wr_req_q, data_wr_req_d;
   logic [31:0]     load_data_q, load_data_d, last_addr_q, last_addr_d;
   logic [4:0]      load_rd_q, load_rd_d;
   logic            load_write_q, load_write_d, store_done_q, store_done_d;
   logic            misaligned_q, misaligned_d;

   entry_t      req_entry, head;
   logic        push, start, issue, fin;
   logic [63:0] head_lanes;
   logic [7:0]  head_mask;
   logic [3:0]  base_mask;

   assign req_entry = '{addr: req_addr, wdata: req_wdata, ld: req_ld, st: req_st,
                        size: req_size, uns: req_uns, rd: req_rd};
   assign head      = q_mem_q[rd_ptr_q];
   assign req_rdy   = count_q < CW'(DEPTH);
   assign push      = req_vld && req_rdy && !flush;
   // A flush in the same cycle as a would-be issue discards the head too.
   assign start     = (count_q != '0) && !flush && (state_q == IDLE || state_q == DONE);

   always_comb begin
      case (head.size)
         2'd0:    base_mask = 4'b0001;
         2'd1:    base_mask = 4'b0011;
         default: base_mask = 4'b1111;
      endcase
      head_lanes = {32'h0, head.wdata} << {head.addr[1:0], 3'b000};
      head_mask  = {4'h0, base_mask} << head.addr[1:0];
`ifdef KRONOS_LSU_MISALIGN_EN
      issue = 1'b1;
`else
      issue = !is_mis(head.size, head.addr[1:0]);
`endif
   end

   always_ff @(posedge clk) begin
      if (push) q_mem_q[wr_ptr_q] <= req_entry;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
         if (start) rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CW'(push) - CW'(start);
      end
   end

   always_comb begin
      state_d        = state_q;
      cur_d          = cur_q;
      split_d        = split_q;
      lo_d           = lo_q;
      spill_data_d   = spill_data_q;
      spill_mask_d   = spill_mask_q;
      data_addr_d    = data_addr_q;
      data_wr_data_d = data_wr_data_q;
      data_wr_mask_d = data_wr_mask_q;
      data_rd_req_d  = data_rd_req_q;
      data_wr_req_d  = data_wr_req_q;
      load_data_d    = load_data_q;
      load_rd_d      = load_rd_q;
      last_addr_d    = last_addr_q;
      load_write_d   = 1'b0;
      store_done_d   = 1'b0;
      misaligned_d   = 1'b0;
      fin            = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               state_d        = ACC0;
               cur_d          = head;
               split_d        = is_mis(head.size, head.addr[1:0]);
               data_addr_d    = {head.addr[31:2], 2'b00};
               data_wr_data_d = head_lanes[31:0];
               data_wr_mask_d = (head.st && issue) ? head_mask[3:0] : '0;
               spill_data_d   = head_lanes[63:32];
               spill_mask_d   = head.st ? head_mask[7:4] : '0;
               data_rd_req_d  = head.ld && issue;
               data_wr_req_d  = head.st && issue;
            end
         end
         ACC0: begin
`ifndef KRONOS_LSU_MISALIGN_EN
            if (split_q) begin
               state_d      = DONE;
               misaligned_d = 1'b1;
               last_addr_d  = cur_q.addr;
            end else
`endif
            if (data_gnt) begin
               if (split_q) begin
                  state_d        = ACC1;
                  lo_d           = data_rd_data;
                  data_addr_d    = data_addr_q + 32'd4;
                  data_wr_data_d = spill_data_q;
                  data_wr_mask_d = spill_mask_q;
               end else begin
                  fin = 1'b1;
               end
            end
         end
         ACC1: fin = data_gnt;
      endcase
      if (fin) begin
         state_d        = DONE;
         data_rd_req_d  = 1'b0;
         data_wr_req_d  = 1'b0;
         data_wr_mask_d = '0;
         load_write_d   = cur_q.ld;
         store_done_d   = cur_q.st;
         last_addr_d    = cur_q.addr;
         if (cur_q.ld) begin
            load_rd_d   = cur_q.rd;
            load_data_d = ld_ext(cur_q.size, cur_q.uns, cur_q.addr[1:0],
                                 (state_q == ACC1) ? lo_q : data_rd_data,
                                 (state_q == ACC1) ? data_rd_data : 32'h0);
         end
      end
   end

   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         state_q        <= IDLE;
         cur_q          <= '0;
         split_q        <= 1'b0;
         lo_q           <= '0;
         spill_data_q   <= '0;
         spill_mask_q   <= '0;
         data_addr_q    <= '0;
         data_wr_data_q <= '0;
         data_wr_mask_q <= '0;
         data_rd_req_q  <= 1'b0;
         data_wr_req_q  <= 1'b0;
         load_data_q    <= '0;
         load_rd_q      <= '0;
         load_write_q   <= 1'b0;
         store_done_q   <= 1'b0;
         misaligned_q   <= 1'b0;
         last_addr_q    <= BOOT_ADDR;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         state_q        <= state_d;
         cur_q          <= cur_d;
         split_q        <= split_d;
         lo_q           <= lo_d;
         spill_data_q   <= spill_data_d;
         spill_mask_q   <= spill_mask_d;
         data_addr_q    <= data_addr_d;
         data_wr_data_q <= data_wr_data_d;
         data_wr_mask_q <= data_wr_mask_d;
         data_rd_req_q  <= data_rd_req_d;
         data_wr_req_q  <= data_wr_req_d;
         load_data_q    <= load_data_d;
         load_rd_q      <= load_rd_d;
         load_write_q   <= load_write_d;
         store_done_q   <= store_done_d;
         misaligned_q   <= misaligned_d;
         last_addr_q    <= last_addr_d;
      end
   end

   assign data_addr    = data_addr_q;
   assign data_wr_data = data_wr_data_q;
   assign data_wr_mask = data_wr_mask_q;
   assign data_rd_req  = data_rd_req_q;
   assign data_wr_req  = data_wr_req_q;
   assign load_data    = load_data_q;
   assign load_rd      = load_rd_q;
   assign load_write   = load_write_q;
   assign store_done   = store_done_q;
   assign misaligned   = misaligned_q;
   assign last_addr    = last_addr_q;
   assign busy         = (count_q != '0) || (state_q != IDLE);
endmodule

// File: tb/tb_kronos_lsu_q.sv
// Directed bench for kronos_lsu_q: loads, stores, misaligned handling, queue full/flush, reset mid-access.
module tb_kronos_lsu_q;
   logic        clk = 1'b0;
   logic        rstz;
   logic        req_vld, req_rdy, req_ld, req_st, req_uns, flush;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic [4:0]  req_rd;
   logic [31:0] data_addr, data_wr_data, data_rd_data;
   logic [3:0]  data_wr_mask;
   logic        data_rd_req, data_wr_req, data_gnt;
   logic [31:0] load_data, last_addr;
   logic [4:0]  load_rd;
   logic        load_write, store_done, misaligned, busy;

   logic        gnt_en;
   logic [31:0] mem [256];
   int          checks = 0;
   int          errors = 0;
   int          rd_cnt = 0;
   logic [31:0] rd_addr_prev = '0, rd_addr_last = '0;
   logic [31:0] cap_data = '0, cap_addr = '0;
   logic [3:0]  cap_mask = '0;

   kronos_lsu_q #(.DEPTH(2), .BOOT_ADDR(32'h0)) dut (
      .clk(clk), .rstz(rstz),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ld(req_ld), .req_st(req_st), .req_size(req_size), .req_uns(req_uns), .req_rd(req_rd),
      .flush(flush),
      .data_addr(data_addr), .data_wr_data(data_wr_data), .data_wr_mask(data_wr_mask),
      .data_rd_req(data_rd_req), .data_wr_req(data_wr_req), .data_rd_data(data_rd_data),
      .data_gnt(data_gnt),
      .load_data(load_data), .load_rd(load_rd), .load_write(load_write),
      .store_done(store_done), .misaligned(misaligned), .busy(busy), .last_addr(last_addr)
   );

   always #5 clk = ~clk;

   assign data_gnt     = gnt_en && (data_rd_req || data_wr_req);
   assign data_rd_data = mem[data_addr[9:2]];

   always @(posedge clk) begin
      if (data_rd_req && data_gnt) begin
         rd_cnt       <= rd_cnt + 1;
         rd_addr_prev <= rd_addr_last;
         rd_addr_last <= data_addr;
      end
      if (data_wr_req && data_gnt) begin
         cap_data <= data_wr_data;
         cap_mask <= data_wr_mask;
         cap_addr <= data_addr;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic send(input logic ld, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns, input logic [4:0] rd);
      int n = 0;
      while (!req_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_rdy) check("send_timeout", 32'd0, 32'd1);
      req_vld = 1'b1; req_ld = ld; req_st = !ld; req_addr = addr;
      req_wdata = wdata; req_size = size; req_uns = uns; req_rd = rd;
      @(negedge clk);
      req_vld = 1'b0;
   endtask

   task automatic wait_done(output int n, output logic lw, output logic sd, output logic mis);
      n = 0; lw = 1'b0; sd = 1'b0; mis = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         n++;
         if (load_write || store_done || misaligned) begin
            lw = load_write; sd = store_done; mis = misaligned;
            break;
         end
      end
      if (!(lw || sd || mis)) check("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n, base, extra;
      logic lw, sd, mis;
      rstz = 1'b0; gnt_en = 1'b1; flush = 1'b0;
      req_vld = 1'b0; req_ld = 1'b0; req_st = 1'b0; req_addr = '0; req_wdata = '0;
      req_size = '0; req_uns = 1'b0; req_rd = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      repeat (3) @(negedge clk);
      check("rst_rdy", req_rdy, 1);
      check("rst_busy", busy, 0);
      check("rst_rdreq", data_rd_req, 0);
      check("rst_wrreq", data_wr_req, 0);
      check("rst_mask", data_wr_mask, 0);
      check("rst_lw", load_write, 0);
      check("rst_sd", store_done, 0);
      check("rst_mis", misaligned, 0);
      check("rst_last", last_addr, 32'h0);
      rstz = 1'b1;
      @(negedge clk);

      // aligned word load
      mem[8'h40] = 32'hDEADBEEF;
      send(1'b1, 32'h100, 32'h0, 2'd2, 1'b0, 5'd7);
      wait_done(n, lw, sd, mis);
      check("lw_lat", n, 2);
      check("lw_pulse", lw, 1);
      check("lw_data", load_data, 32'hDEADBEEF);
      check("lw_rd", load_rd, 7);
      check("lw_last", last_addr, 32'h100);
      @(negedge clk);
      check("lw_pulse_end", load_write, 0);
      check("lw_idle", busy, 0);

      // sub-word loads with sign/zero extension
      mem[8'h40] = 32'h80112233;
      send(1'b1, 32'h103, 32'h0, 2'd0, 1'b0, 5'd3);
      wait_done(n, lw, sd, mis);
      check("lb_s", load_data, 32'hFFFFFF80);
      send(1'b1, 32'h103, 32'h0, 2'd0, 1'b1, 5'd3);
      wait_done(n, lw, sd, mis);
      check("lb_u", load_data, 32'h00000080);
      send(1'b1, 32'h102, 32'h0, 2'd1, 1'b0, 5'd4);
      wait_done(n, lw, sd, mis);
      check("lh_s", load_data, 32'hFFFF8011);

      // half store at upper lanes
      send(1'b0, 32'h102, 32'h0000ABCD, 2'd1, 1'b0, 5'd0);
      wait_done(n, lw, sd, mis);
      check("sh_done", sd, 1);
      check("sh_nolw", lw, 0);
      check("sh_mask", cap_mask, 4'b1100);
      check("sh_data", cap_data, 32'hABCD0000);
      check("sh_addr", cap_addr, 32'h100);
      check("sh_last", last_addr, 32'h102);

      // misaligned word load
      mem[8'h40] = 32'h44332211;
      mem[8'h41] = 32'h88776655;
      base = rd_cnt;
      send(1'b1, 32'h101, 32'h0, 2'd2, 1'b0, 5'd9);
      wait_done(n, lw, sd, mis);
`ifdef KRONOS_LSU_MISALIGN_EN
      check("mis_lw", lw, 1);
      check("mis_data", load_data, 32'h55443322);
      check("mis_grants", rd_cnt - base, 2);
      check("mis_a0", rd_addr_prev, 32'h100);
      check("mis_a1", rd_addr_last, 32'h104);
      check("mis_flag", misaligned, 0);
`else
      check("mis_flag", mis, 1);
      check("mis_nolw", lw, 0);
      check("mis_grants", rd_cnt - base, 0);
      check("mis_last", last_addr, 32'h101);
      @(negedge clk);
      check("mis_pulse_end", misaligned, 0);
`endif

      // queue fills with grant withheld, then flush
      gnt_en = 1'b0;
      base = rd_cnt;
      send(1'b1, 32'h100, 32'h0, 2'd2, 1'b0, 5'd11);
      send(1'b1, 32'h104, 32'h0, 2'd2, 1'b0, 5'd12);
      send(1'b1, 32'h108, 32'h0, 2'd2, 1'b0, 5'd13);
      check("full_rdy", req_rdy, 0);
      check("full_busy", busy, 1);
      check("full_acc", data_rd_req, 1);
      check("full_addr", data_addr, 32'h100);
      @(negedge clk);
      check("full_hold", req_rdy, 0);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_rdy", req_rdy, 1);
      check("flush_inflight", data_rd_req, 1);
      gnt_en = 1'b1;
      wait_done(n, lw, sd, mis);
      check("flush_lw", lw, 1);
      check("flush_rd", load_rd, 11);
      check("flush_data", load_data, 32'h44332211);
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (load_write) extra++;
      end
      check("flush_noextra", extra, 0);
      check("flush_grants", rd_cnt - base, 1);
      check("flush_idle", busy, 0);

      // flush beats a simultaneous enqueue
      req_vld = 1'b1; req_ld = 1'b1; req_st = 1'b0; req_addr = 32'h100;
      req_size = 2'd2; req_rd = 5'd14; flush = 1'b1;
      @(negedge clk);
      req_vld = 1'b0; flush = 1'b0;
      check("fe_busy", busy, 0);
      check("fe_rdy", req_rdy, 1);

      // reset while in ACC0
      gnt_en = 1'b0;
      send(1'b1, 32'h104, 32'h0, 2'd2, 1'b0, 5'd15);
      n = 0;
      while (!data_rd_req && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("rst_acc0", data_rd_req, 1);
      rstz = 1'b0;
      #1;
      check("rstm_rdreq", data_rd_req, 0);
      check("rstm_busy", busy, 0);
      check("rstm_rdy", req_rdy, 1);
      check("rstm_last", last_addr, 32'h0);
      gnt_en = 1'b1;
      @(negedge clk);
      rstz = 1'b1;
      extra = 0;
      repeat (4) begin
         @(negedge clk);
         if (load_write) extra++;
      end
      check("rstm_nolw", extra, 0);
      send(1'b1, 32'h104, 32'h0, 2'd2, 1'b0, 5'd16);
      wait_done(n, lw, sd, mis);
      check("post_rst_lat", n, 2);
      check("post_rst_data", load_data, 32'h88776655);
      check("post_rst_rd", load_rd, 16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
